// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the RX path (and the TX path's CRC reuse).
// Contents: preamble/SFD byte values, CRC-32 init/polynomial/good-frame residue,
// broadcast address, and the RX sequencer state type.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_CRC_POLY    = 32'h04C1_1DB7;
  // Register value after a good frame's FCS has been folded in (non-reflected form).
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [47:0] ETH_BCAST       = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

endpackage

// File: rtl/eth_crc32.sv
// Combinational byte-wide CRC-32 step (Ethernet polynomial 04C11DB7).
// The register is kept MSB-first while data bits are consumed LSB-first, which is the
// bit-reversed equivalent of the usual reflected implementation.
// Ports:
//   crc_in  [31:0]  current CRC register
//   data    [7:0]   byte to fold in (bit 0 first on the wire)
//   crc_out [31:0]  CRC register after the byte
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) begin
        c = {c[30:0], 1'b0} ^ ETH_CRC_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// RX frame sequencer in the rxc domain: finds preamble/SFD, filters on destination MAC,
// strips and checks the FCS, and delivers payload on a valid/last/err stream.
// Ports:
//   clk, rst            rxc clock, synchronous active-high reset
//   rx_dv, rx_er, rxd   RGMII receiver byte stream (decoded error = rx_dv ^ rx_er)
//   promisc             1 = accept every destination address
//   m_data/m_valid/m_last/m_err  payload stream (dest MAC onward, FCS excluded)
//   cnt_ok/cnt_err/cnt_drop      saturating per-frame statistics
module eth_rx_frame_ctrl
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter int unsigned MIN_LEN  = 64,
  parameter int unsigned MAX_LEN  = 1518,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [7:0]       rxd,
  input  logic             promisc,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             m_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err,
  output logic [CNT_W-1:0] cnt_drop
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
  // Depth of the delay line: the last 4 bytes held at dv fall are the FCS.
  localparam int unsigned DLY   = 5;

  rx_state_t state_q, state_d;
  logic      dv_q;
  logic      rise, rx_err_dec;

  logic [31:0]          crc_q, crc_d, crc_next;
  logic [LEN_W-1:0]     len_q, len_d, len_inc;
  logic                 err_q, err_d;
  logic [DLY-1:0][7:0]  line_q, line_d;  // line_q[DLY-1] is the oldest byte
  logic                 addr_miss;

  logic [7:0] m_data_q, m_data_d;
  logic       m_valid_q, m_valid_d, m_last_q, m_last_d, m_err_q, m_err_d;
  logic       inc_ok, inc_err, inc_drop;
  logic [CNT_W-1:0] cnt_ok_q, cnt_err_q, cnt_drop_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  eth_crc32 u_crc (
    .crc_in  (crc_q),
    .data    (rxd),
    .crc_out (crc_next)
  );

  // dv_q resets to 1 so a frame already in flight at reset release never looks like a start.
  assign rise       = rx_dv & ~dv_q;
  assign rx_err_dec = rx_dv ^ rx_er;
  assign len_inc    = (&len_q) ? len_q : len_q + 1'b1;
  // Bytes 1..5 sit in the line and byte 6 is on rxd when the filter is evaluated.
  assign addr_miss  = ({line_q, rxd} != MAC_ADDR) && ({line_q, rxd} != ETH_BCAST);

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    err_d     = err_q;
    line_d    = line_q;
    m_data_d  = m_data_q;
    m_valid_d = 1'b0;
    m_last_d  = 1'b0;
    m_err_d   = 1'b0;
    inc_ok    = 1'b0;
    inc_err   = 1'b0;
    inc_drop  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          if (rxd == ETH_PREAMBLE) begin
            state_d = PREAMBLE;
          end else begin
            state_d  = DROP;
            inc_drop = 1'b1;
          end
        end
      end

      PREAMBLE: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else if (rxd == ETH_SFD) begin
          state_d = DATA;
          crc_d   = ETH_CRC_INIT;
          len_d   = '0;
          err_d   = 1'b0;
        end else if (rxd != ETH_PREAMBLE) begin
          state_d  = DROP;
          inc_drop = 1'b1;
        end
      end

      DATA: begin
        if (rx_dv) begin
          crc_d  = crc_next;
          len_d  = len_inc;
          line_d = {line_q[DLY-2:0], rxd};
          if (rx_err_dec) begin
            err_d = 1'b1;
          end
          if (len_inc == LEN_W'(MAX_LEN + 1)) begin
            // Oversize: close the frame on the held byte and discard the rest.
            m_data_d  = line_q[DLY-1];
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            m_err_d   = 1'b1;
            inc_err   = 1'b1;
            state_d   = DROP;
          end else if (len_inc == LEN_W'(DLY + 1) && !promisc && addr_miss) begin
            state_d  = DROP;
            inc_drop = 1'b1;
          end else if (len_q >= LEN_W'(DLY)) begin
            m_data_d  = line_q[DLY-1];
            m_valid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          if (len_q >= LEN_W'(DLY)) begin
            m_data_d  = line_q[DLY-1];
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            m_err_d   = err_q | (len_q < LEN_W'(MIN_LEN)) | (crc_q != ETH_CRC_RESIDUE);
            inc_ok    = ~m_err_d;
            inc_err   = m_err_d;
          end else begin
            inc_err = 1'b1;
          end
        end
      end

      DROP: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dv_q       <= 1'b1;
      crc_q      <= ETH_CRC_INIT;
      len_q      <= '0;
      err_q      <= 1'b0;
      line_q     <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_err_q    <= 1'b0;
      cnt_ok_q   <= '0;
      cnt_err_q  <= '0;
      cnt_drop_q <= '0;
    end else begin
      state_q   <= state_d;
      dv_q      <= rx_dv;
      crc_q     <= crc_d;
      len_q     <= len_d;
      err_q     <= err_d;
      line_q    <= line_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_err_q   <= m_err_d;
      if (inc_ok) begin
        cnt_ok_q <= sat_inc(cnt_ok_q);
      end
      if (inc_err) begin
        cnt_err_q <= sat_inc(cnt_err_q);
      end
      if (inc_drop) begin
        cnt_drop_q <= sat_inc(cnt_drop_q);
      end
    end
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign m_err    = m_err_q;
  assign cnt_ok   = cnt_ok_q;
  assign cnt_err  = cnt_err_q;
  assign cnt_drop = cnt_drop_q;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Bench for eth_rx_frame_ctrl: table of whole-frame vectors plus hand-written sequences
// for reset-in-flight, bad preamble, preamble abort and back-to-back frames.
module tb_eth_rx_frame_ctrl;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam int MAXL = 1518;
  localparam int NV   = 12;

  logic        clk = 1'b0;
  logic        rst, rx_dv, rx_er, promisc;
  logic [7:0]  rxd;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_err;
  logic [15:0] cnt_ok, cnt_err, cnt_drop;

  eth_rx_frame_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .rx_dv    (rx_dv),
    .rx_er    (rx_er),
    .rxd      (rxd),
    .promisc  (promisc),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_err    (m_err),
    .cnt_ok   (cnt_ok),
    .cnt_err  (cnt_err),
    .cnt_drop (cnt_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          plen;
    logic [47:0] dest;
    bit          prom;
    bit          corrupt;
    int          err_idx;
    int          exp_n;
    bit          exp_last;
    bit          exp_err;
    int          d_ok;
    int          d_err;
    int          d_drop;
  } vec_t;

  vec_t vt [NV];

  int n_chk = 0;
  int n_pass = 0;
  int exp_ok = 0;
  int exp_err = 0;
  int exp_drop = 0;

  // Monitor state: written only by the monitor process.
  int         cyc = 0;
  logic [7:0] cap[$];
  int         vcyc[$];
  int         n_last = 0;
  logic       last_err = 1'b0;
  int         last_cyc = 0;

  // Frame under construction: pay = expected payload, fr = bytes after SFD incl FCS.
  logic [7:0] pay[$];
  logic [7:0] fr[$];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        cap.push_back(m_data);
        vcyc.push_back(cyc);
        if (m_last === 1'b1) begin
          n_last++;
          last_err = m_err;
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Standard reflected CRC-32 (shift right, EDB88320).
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic vec_t mk(input int plen, input logic [47:0] dest, input bit prom,
                              input bit cor, input int ei, input int n, input bit l,
                              input bit e, input int ok, input int er, input int dr);
    vec_t v;
    v.plen = plen; v.dest = dest; v.prom = prom; v.corrupt = cor; v.err_idx = ei;
    v.exp_n = n; v.exp_last = l; v.exp_err = e; v.d_ok = ok; v.d_err = er; v.d_drop = dr;
    return v;
  endfunction

  task automatic put(input logic dv, input logic [7:0] d, input logic er);
    rx_dv = dv;
    rxd   = d;
    rx_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic build(input int plen, input logic [47:0] dest, input bit corrupt);
    logic [31:0] c;
    logic [7:0]  b;
    pay.delete();
    fr.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < plen; i++) begin
      if (i < 6)       b = dest[47-8*i -: 8];
      else if (i == 6) b = 8'h02;
      else if (i < 11) b = 8'h00;
      else if (i == 11) b = 8'hAA;
      else             b = 8'((i * 37 + plen) & 255);
      pay.push_back(b);
      fr.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    if (corrupt) begin
      b = fr[plen];
      b[0] = ~b[0];
      fr[plen] = b;
    end
  endtask

  // Sends preamble, SFD, fr[], then gap cycles of dv=0 (a short carrier extension inside
  // longer gaps). Returns the cycle stamps of byte 6, byte MAXL+1 and the dv=0 sample.
  task automatic send(input int err_idx, input int gap, output int c6, output int c_over,
                      output int c_end);
    c6 = 0;
    c_over = 0;
    for (int i = 0; i < 7; i++) put(1'b1, 8'h55, 1'b1);
    put(1'b1, 8'hD5, 1'b1);
    for (int i = 0; i < fr.size(); i++) begin
      put(1'b1, fr[i], (i + 1 == err_idx) ? 1'b0 : 1'b1);
      if (i + 1 == 6) c6 = cyc;
      if (i + 1 == MAXL + 1) c_over = cyc;
    end
    put(1'b0, 8'h00, 1'b0);
    c_end = cyc;
    for (int g = 1; g < gap; g++) put(1'b0, 8'h0F, (g == 3 || g == 4));
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_cnt_ok"}, cnt_ok, exp_ok);
    check({tag, "_cnt_err"}, cnt_err, exp_err);
    check({tag, "_cnt_drop"}, cnt_drop, exp_drop);
  endtask

  task automatic run_row(input string tag, input vec_t v);
    int base, nl0, c6, cov, cend, first, mism;
    base = cap.size();
    nl0  = n_last;
    promisc = v.prom;
    build(v.plen, v.dest, v.corrupt);
    send(v.err_idx, 12, c6, cov, cend);
    exp_ok   += v.d_ok;
    exp_err  += v.d_err;
    exp_drop += v.d_drop;
    check({tag, "_n_valid"}, cap.size() - base, v.exp_n);
    check({tag, "_n_last"}, n_last - nl0, v.exp_last);
    if (v.exp_last) begin
      check({tag, "_m_err"}, last_err, v.exp_err);
      check({tag, "_last_cyc"}, last_cyc, (v.plen + 4 > MAXL) ? cov : cend);
    end
    if (v.exp_n > 0 && v.plen + 4 >= 6) begin
      first = (cap.size() > base) ? vcyc[base] : -1;
      check({tag, "_first_cyc"}, first, c6);
    end
    mism = 0;
    for (int i = 0; i < v.exp_n && base + i < cap.size(); i++) begin
      if (cap[base+i] !== pay[i]) mism++;
    end
    check({tag, "_data_mismatches"}, mism, 0);
    check_cnts(tag);
  endtask

  initial begin
    int base, nl0, c6, cov, cend, mism;

    vt[0]  = mk(60,   MAC,   0, 0, 0,  60,   1, 0, 1, 0, 0);
    vt[1]  = mk(60,   MAC,   0, 1, 0,  60,   1, 1, 0, 1, 0);
    vt[2]  = mk(60,   OTHER, 0, 0, 0,  0,    0, 0, 0, 0, 1);
    vt[3]  = mk(60,   OTHER, 1, 0, 0,  60,   1, 0, 1, 0, 0);
    vt[4]  = mk(40,   BCAST, 0, 0, 0,  40,   1, 1, 0, 1, 0);
    vt[5]  = mk(1596, MAC,   0, 0, 0,  1514, 1, 1, 0, 1, 0);
    vt[6]  = mk(60,   MAC,   0, 0, 20, 60,   1, 1, 0, 1, 0);
    vt[7]  = mk(1514, MAC,   0, 0, 0,  1514, 1, 0, 1, 0, 0);
    vt[8]  = mk(1515, MAC,   0, 0, 0,  1514, 1, 1, 0, 1, 0);
    vt[9]  = mk(59,   MAC,   0, 0, 0,  59,   1, 1, 0, 1, 0);
    vt[10] = mk(0,    MAC,   0, 0, 0,  0,    0, 0, 0, 1, 0);
    vt[11] = mk(1,    MAC,   0, 0, 0,  1,    1, 1, 0, 1, 0);

    // Reset while a frame is already on the wire; that frame must be ignored.
    rst = 1'b1; rx_dv = 1'b1; rx_er = 1'b1; rxd = 8'h55; promisc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_err", m_err, 0);
    check("rst_m_data", m_data, 0);
    check_cnts("rst");
    for (int i = 0; i < 4; i++) put(1'b1, 8'h55, 1'b1);
    put(1'b1, 8'hD5, 1'b1);
    for (int i = 0; i < 30; i++) put(1'b1, 8'h02, 1'b1);
    for (int i = 0; i < 8; i++) put(1'b0, 8'h00, 1'b0);
    check("inflight_n_valid", cap.size(), 0);
    check_cnts("inflight");

    for (int r = 0; r < NV; r++) run_row($sformatf("vec%0d", r), vt[r]);

    // Bad byte inside the preamble.
    base = cap.size();
    for (int i = 0; i < 3; i++) put(1'b1, 8'h55, 1'b1);
    put(1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 20; i++) put(1'b1, 8'h11, 1'b1);
    for (int i = 0; i < 6; i++) put(1'b0, 8'h00, 1'b0);
    exp_drop++;
    check("badpre_n_valid", cap.size() - base, 0);
    check_cnts("badpre");

    // First byte after dv rise is not a preamble byte.
    put(1'b1, 8'hD5, 1'b1);
    for (int i = 0; i < 20; i++) put(1'b1, 8'h22, 1'b1);
    for (int i = 0; i < 6; i++) put(1'b0, 8'h00, 1'b0);
    exp_drop++;
    check("nopre_n_valid", cap.size() - base, 0);
    check_cnts("nopre");

    // Preamble cut short by dv falling: silently back to idle.
    for (int i = 0; i < 3; i++) put(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 6; i++) put(1'b0, 8'h00, 1'b0);
    check("abort_n_valid", cap.size() - base, 0);
    check_cnts("abort");

    // Back-to-back frames: the second dv rise lands on the m_last cycle of the first.
    promisc = 1'b0;
    build(60, MAC, 0);
    base = cap.size();
    nl0  = n_last;
    send(0, 1, c6, cov, cend);
    send(0, 12, c6, cov, cend);
    exp_ok += 2;
    check("b2b_n_valid", cap.size() - base, 120);
    check("b2b_n_last", n_last - nl0, 2);
    mism = 0;
    for (int i = 0; i < 120 && base + i < cap.size(); i++) begin
      if (cap[base+i] !== pay[i % 60]) mism++;
    end
    check("b2b_data_mismatches", mism, 0);
    check_cnts("b2b");

    // One-cycle reset at byte 20: rest of that frame is ignored, next frame is fine.
    build(60, MAC, 0);
    for (int i = 0; i < 7; i++) put(1'b1, 8'h55, 1'b1);
    put(1'b1, 8'hD5, 1'b1);
    for (int i = 0; i < 19; i++) put(1'b1, fr[i], 1'b1);
    rst = 1'b1;
    put(1'b1, fr[19], 1'b1);
    rst = 1'b0;
    base = cap.size();
    nl0  = n_last;
    for (int i = 20; i < fr.size(); i++) put(1'b1, fr[i], 1'b1);
    for (int i = 0; i < 12; i++) put(1'b0, 8'h00, 1'b0);
    exp_ok = 0;
    exp_err = 0;
    exp_drop = 0;
    check("midrst_n_valid", cap.size() - base, 0);
    check("midrst_n_last", n_last - nl0, 0);
    check_cnts("midrst");
    run_row("after_rst", vt[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
